// File: rtl/icache_fill_ctrl_pkg.sv
// Shared types for the instruction-cache miss/fill controller.
package icache_fill_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DONE,
        FENCE
    } icache_fill_state_t;

endpackage

// File: rtl/icache_fill_ctrl_cycler.sv
// One-hot rotate-left by one position, wrapping MSB to LSB; used for victim selection.
module icache_fill_ctrl_cycler #(
    parameter int WAYS = 2
) (
    input  logic [WAYS-1:0] cur,
    output logic [WAYS-1:0] nxt
);

    generate
        if (WAYS == 1) begin : g_single
            assign nxt = cur;
        end else begin : g_rotate
            assign nxt = {cur[WAYS-2:0], cur[WAYS-1]};
        end
    endgenerate

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache miss handler: victim select, memory line fill, tag update and ifence sweep.
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int WAYS        = 2,
    parameter int LINE_ADDR_W = 4,
    parameter int TAG_W       = 20,
    parameter int SUB_LINE_W  = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              miss_req,
    input  logic [TAG_W-1:0]                  miss_tag,
    input  logic [LINE_ADDR_W-1:0]            miss_line_addr,
    input  logic [SUB_LINE_W-1:0]             miss_word,
    input  logic                              ifence_req,
    output logic                              mem_req,
    output logic [TAG_W+LINE_ADDR_W-1:0]      mem_addr,
    input  logic                              mem_ack,
    input  logic                              mem_rvalid,
    input  logic [31:0]                       mem_rdata,
    output logic                              data_we,
    output logic [WAYS-1:0]                   data_way,
    output logic [LINE_ADDR_W+SUB_LINE_W-1:0] data_addr,
    output logic [31:0]                       data_wdata,
    output logic                              fwd_valid,
    output logic [31:0]                       fwd_data,
    output logic                              update,
    output logic [WAYS-1:0]                   update_way,
    output logic                              ifence,
    output logic [LINE_ADDR_W-1:0]            ifence_addr,
    output logic                              busy,
    output logic                              fill_done
);

    localparam logic [SUB_LINE_W-1:0]  LAST_BEAT = '1;
    localparam logic [LINE_ADDR_W-1:0] LAST_LINE = '1;

    icache_fill_state_t     state;
    logic [TAG_W-1:0]       tag_r;
    logic [LINE_ADDR_W-1:0] line_r;
    logic [SUB_LINE_W-1:0]  word_r;
    logic [WAYS-1:0]        victim_r;
    logic [WAYS-1:0]        victim_ptr;
    logic [WAYS-1:0]        victim_next;
    logic [SUB_LINE_W-1:0]  beat_cnt;
    logic [LINE_ADDR_W-1:0] fence_cnt;
    logic                   fence_pending;

    icache_fill_ctrl_cycler #(.WAYS(WAYS)) u_cycler (
        .cur (victim_ptr),
        .nxt (victim_next)
    );

    // NOTE: every register here uses <= so all updates see the pre-edge state, and the
    // async reset branch clears the partial line and any pending fence at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            tag_r         <= '0;
            line_r        <= '0;
            word_r        <= '0;
            victim_r      <= '0;
            victim_ptr    <= WAYS'(1);
            beat_cnt      <= '0;
            fence_cnt     <= '0;
            fence_pending <= 1'b0;
        end else begin
            // A fence arriving mid-fill is deferred until the line is committed.
            if (ifence_req && (state inside {REQ, FILL, DONE}))
                fence_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (ifence_req || fence_pending) begin
                        state <= FENCE;
                    end else if (miss_req) begin
                        state    <= REQ;
                        tag_r    <= miss_tag;
                        line_r   <= miss_line_addr;
                        word_r   <= miss_word;
                        victim_r <= victim_ptr;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= FILL;
                        beat_cnt <= '0;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT)
                            state <= DONE;
                    end
                end
                DONE: begin
                    victim_ptr <= victim_next;
                    state      <= (fence_pending || ifence_req) ? FENCE : IDLE;
                end
                FENCE: begin
                    fence_cnt <= fence_cnt + 1'b1;
                    if (fence_cnt == LAST_LINE) begin
                        state         <= IDLE;
                        fence_cnt     <= '0;
                        fence_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so a reset drops them without waiting for a clock.
    assign busy        = (state != IDLE);
    assign mem_req     = (state == REQ);
    assign mem_addr    = {tag_r, line_r};

    assign data_we     = (state == FILL) && mem_rvalid;
    assign data_way    = data_we ? victim_r : '0;
    assign data_addr   = {line_r, beat_cnt};
    assign data_wdata  = data_we ? mem_rdata : '0;

    assign fwd_valid   = data_we && (beat_cnt == word_r);
    assign fwd_data    = fwd_valid ? mem_rdata : '0;

    assign update      = (state == DONE);
    assign update_way  = update ? victim_r : '0;
    assign fill_done   = update;

    assign ifence      = (state == FENCE);
    assign ifence_addr = fence_cnt;

endmodule
